// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between NREQ requesters.
// Each operation is granted in IDLE, executed for one cycle in EXEC and held
// in RESP until the owner accepts the result.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin arbitration.
module alu_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [4*NREQ-1:0]    req_ctrl,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_res,
  output logic                 resp_zero,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_ctrl,
  input  logic [31:0]          alu_res,
  input  logic                 alu_zero
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   owner_q;
  logic [31:0]       op_a_q;
  logic [31:0]       op_b_q;
  logic [3:0]        op_ctrl_q;
  logic [31:0]       res_q;
  logic              zero_q;

  logic [PtrW-1:0]   win;
  logic              win_found;
  logic [PtrW-1:0]   ptr_next;

  // Pick the first valid requester, searching upward from the base index with wrap.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (32'(ptr_q) + k) % NREQ;
`endif
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win       = PtrW'(idx);
      end
    end
  end

  // Pointer moves just past the owner once its response is accepted.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    ptr_next = '0;
`else
    ptr_next = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif
  end

  // Grant is combinational; suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && win_found && !reset) begin
      req_ready[win] = 1'b1;
    end
  end

  // Response valid is a one-hot decode of the owner while in RESP.
  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_ctrl  = op_ctrl_q;
  assign resp_res  = res_q;
  assign resp_zero = zero_q;

  // FSM and datapath registers; operands only change on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_ctrl_q <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            op_a_q    <= req_a[32*win +: 32];
            op_b_q    <= req_b[32*win +: 32];
            op_ctrl_q <= req_ctrl[4*win +: 4];
            owner_q   <= win;
            state_q   <= StExec;
          end
        end
        StExec: begin
          res_q   <= alu_res;
          zero_q  <= alu_zero;
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            ptr_q   <= ptr_next;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU datapath between `NREQ` requesters, such as a pipeline execute stage and a multi-cycle helper unit. Arbitration is round-robin. The block registers the winning operands, drives them to the external ALU for one cycle, captures the result and zero flag, and holds them on a response channel until the owner accepts them. It sits between the requesters and the ALU instance and owns the ALU's `SrcA`/`SrcB`/`ALUCtrl` inputs exclusively.

## Interface
- `NREQ`, default 2: number of requesters. Legal range is 2..4.
- `clk` input, 1: single clock. All state updates on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `req_valid` input, NREQ: per-requester operation request.
- `req_ready` output, NREQ: one-hot grant/accept. Combinational.
- `req_a` input, 32*NREQ: SrcA operands. Requester i occupies bits [32i+31:32i].
- `req_b` input, 32*NREQ: SrcB operands, same packing.
- `req_ctrl` input, 4*NREQ: ALU control codes. Requester i occupies bits [4i+3:4i].
- `resp_valid` output, NREQ: one-hot, asserted for the owner of the result.
- `resp_ready` input, NREQ: per-requester result accept.
- `resp_res` output, 32: captured ALU result. Shared by all requesters.
- `resp_zero` output, 1: captured zero flag.
- `alu_a` output, 32: drives ALU SrcA.
- `alu_b` output, 32: drives ALU SrcB.
- `alu_ctrl` output, 4: drives ALU ALUCtrl.
- `alu_res` input, 32: from ALU ALURes.
- `alu_zero` input, 1: from ALU Zero.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Encoding is free.
- **IDLE:**
  - Winner is the first i with `req_valid[i]=1`, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[winner]=1` in the same cycle. All other bits of `req_ready` are 0.
  - On the edge: latch `req_a`/`req_b`/`req_ctrl` of the winner into the operand registers, latch `owner=winner`, go to EXEC.
  - No valid request: stay in IDLE, `req_ready=0`.
- **EXEC:**
  - `alu_a`/`alu_b`/`alu_ctrl` are driven from the operand registers. The ALU is combinational.
  - On the edge: capture `alu_res`→`resp_res` and `alu_zero`→`resp_zero`, go to RESP.
- **RESP:**
  - `resp_valid[owner]=1`, all other bits 0. `resp_res` and `resp_zero` are held stable.
  - On `resp_ready[owner]=1`: go to IDLE, set `ptr=(owner+1) mod NREQ`.
  - `resp_ready` bits of non-owners are ignored.
- `req_ready` is 0 in EXEC and RESP. Only one operation is in flight at a time.
- Operand registers hold their value outside EXEC, so `alu_*` only change on a grant.
- `alu_ctrl` is passed through unmodified. Undefined codes produce the ALU's default (SrcA passthrough); the arbiter does not check them.
- Requesters must not make `req_valid` depend on `req_ready`.
- Once a request is accepted, a requester may change its `req_*` inputs; the operands are already registered.

## Timing
- Reset values:
  - state=IDLE, ptr=0, owner=0.
  - `req_ready=0` (no grant during the reset cycle), `resp_valid=0`.
  - `resp_res=0`, `resp_zero=0`.
  - `alu_a=0`, `alu_b=0`, `alu_ctrl=4'b0`.
- Latency: request accepted in cycle N → `resp_valid` high in cycle N+2.
- Maximum throughput: one operation per 3 cycles, given `resp_ready` tied high.
- Simultaneous requests: exactly one grant, chosen by round-robin from `ptr`.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NREQ-1,0.
- `ptr` wrap-around: when `owner=NREQ-1`, the next `ptr` is 0.
- Back-pressure: RESP is held indefinitely while `resp_ready[owner]=0`. No new grants are issued during that time.
- Reset mid-operation, in EXEC or RESP: the transaction is dropped with no response, and all state returns to its reset value on that edge.
- Reset takes priority over every other transition.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: arbitration is fixed priority, lowest index wins. `ptr` is not used and stays 0.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour is identical in both builds.

## Test plan
- **Single operation:** reset, then requester 0 issues ADD with a=5, b=7.
  - `req_ready[0]` high in cycle N.
  - `resp_valid[0]` high in cycle N+2, `resp_res=12`, `resp_zero=0`.
- **Zero flag:** requester 1 issues SUB with a=b=0x1234.
  - `resp_res=0`, `resp_zero=1`, `resp_valid=2'b10`.
- **Round-robin:** NREQ=2, both requesters valid continuously, `resp_ready=2'b11`.
  - Grants go 0,1,0,1 at cycles 0,3,6,9.
  - With `ALU_ARB_FIXED_PRIO_EN` defined: grants go 0,0,0,0.
- **Back-pressure:** requester 0 issues OR with a=0xF0, b=0x0F, and `resp_ready[0]` is held low for 5 cycles.
  - `resp_res=0xFF` is stable throughout.
  - `req_ready` stays 0 even with requester 1 valid.
  - Requester 1 is granted the cycle after `resp_ready[0]` rises and the FSM returns to IDLE.
- **Reset mid-operation:** assert `reset` during EXEC.
  - Next cycle: `resp_valid=0`, `alu_a`/`alu_b`/`alu_ctrl`=0, `ptr=0`.
  - A following request from requester 1 completes normally with 2-cycle latency.
